// File: rtl/msg_decoder.sv
// Splits a byte-packed payload of length-prefixed records into individual messages,
// one right-justified message per output pulse.
module msg_decoder #(
  parameter int DATA_WIDTH        = 64,
  parameter int OUTPUT_WIDTH      = 256,
  parameter int OUTPUT_MASK_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_startofpayload,
  input  logic                         in_endofpayload,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [2:0]                   in_empty,
  input  logic                         in_error,
  output logic [OUTPUT_WIDTH-1:0]      out_data,
  output logic                         out_valid,
  output logic [OUTPUT_MASK_WIDTH-1:0] out_bytemask
);

  typedef enum logic [2:0] {IDLE, COUNT, LEN, BODY, DROP} state_t;

  state_t                  r_state, w_state;
  logic [15:0]             r_cnt, w_cnt;
  logic [5:0]              r_rem, w_rem;
  logic [5:0]              r_mlen, w_mlen;
  logic                    r_half, w_half;
  logic [7:0]              r_hi, w_hi;
  logic [OUTPUT_WIDTH-1:0] r_msg, w_msg;
  logic                    r_ready;

  logic                    w_acc;
  logic [3:0]              w_nbytes;
  logic                    w_emit;
  logic [OUTPUT_WIDTH-1:0] w_emit_data;
  logic [5:0]              w_emit_len;

  assign in_ready = r_ready;
  assign w_acc    = in_valid & r_ready;
  assign w_nbytes = in_endofpayload ? (4'd8 - {1'b0, in_empty}) : 4'd8;

  // Walk the byte lanes of the accepted beat in stream order; the loop index is the
  // lane pointer. Legal lengths >= 8 guarantee at most one completion per beat.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] fld;
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_rem       = r_rem;
    w_mlen      = r_mlen;
    w_half      = r_half;
    w_hi        = r_hi;
    w_msg       = r_msg;
    w_emit      = 1'b0;
    w_emit_data = '0;
    w_emit_len  = '0;
    b           = '0;
    fld         = '0;
    if (w_acc) begin
      if (in_startofpayload) begin
        w_state = COUNT;
        w_half  = 1'b0;
      end
      if (w_state != IDLE) begin
        for (int i = 0; i < 8; i++) begin
          if (4'(i) < w_nbytes) begin
            b = in_data[8*(7-i) +: 8];
            case (w_state)
              COUNT, LEN: begin
                if (!w_half) begin
                  w_hi   = b;
                  w_half = 1'b1;
                end else begin
                  w_half = 1'b0;
                  fld    = {w_hi, b};
                  if (w_state == COUNT) begin
                    w_cnt   = fld;
                    w_state = (fld == 16'd0) ? DROP : LEN;
                  end else if (fld < 16'd8 || fld > 16'd32) begin
                    w_state = DROP;
                  end else begin
                    w_rem   = fld[5:0];
                    w_mlen  = fld[5:0];
                    w_msg   = '0;
                    w_state = BODY;
                  end
                end
              end
              BODY: begin
                w_msg = {w_msg[OUTPUT_WIDTH-9:0], b};
                w_rem = w_rem - 6'd1;
                if (w_rem == 6'd0) begin
                  w_emit      = 1'b1;
                  w_emit_data = w_msg;
                  w_emit_len  = w_mlen;
                  w_cnt       = w_cnt - 16'd1;
                  w_state     = (w_cnt == 16'd0) ? DROP : LEN;
                end
              end
              default: ;
            endcase
          end
        end
        // End of payload drops any partial message along with the parse context.
        if (in_endofpayload) w_state = IDLE;
        if (in_error) begin
          w_emit  = 1'b0;
          w_state = in_endofpayload ? IDLE : DROP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_mlen       <= '0;
      r_half       <= 1'b0;
      r_hi         <= '0;
      r_msg        <= '0;
      r_ready      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_bytemask <= '0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_rem        <= w_rem;
      r_mlen       <= w_mlen;
      r_half       <= w_half;
      r_hi         <= w_hi;
      r_msg        <= w_msg;
      r_ready      <= 1'b1;
      out_valid    <= w_emit;
      out_data     <= w_emit ? w_emit_data : '0;
      out_bytemask <= w_emit ? ~({OUTPUT_MASK_WIDTH{1'b1}} << w_emit_len) : '0;
    end
  end

endmodule

// File: tb/tb_msg_decoder.sv
// Directed, table-driven bench for msg_decoder: each row is one clock of input and
// the outputs expected right after that clock edge.
module tb_msg_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_startofpayload, in_endofpayload, in_error;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [2:0]   in_empty;
  logic [255:0] out_data;
  logic         out_valid;
  logic [31:0]  out_bytemask;

  int n_chk = 0;
  int n_err = 0;

  msg_decoder dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_startofpayload (in_startofpayload),
    .in_endofpayload   (in_endofpayload),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_error          (in_error),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_bytemask      (out_bytemask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v, sop, eop, err;
    logic [63:0]  d;
    logic [2:0]   e;
    logic         ev;
    logic [255:0] ed;
    logic [31:0]  em;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic sop, input logic eop, input logic err,
                              input logic [63:0] d, input logic [2:0] e,
                              input logic ev, input logic [255:0] ed, input logic [31:0] em);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.err = err; r.d = d; r.e = e;
    r.ev = ev; r.ed = ed; r.em = em;
    return r;
  endfunction

  // Beat with no output expected after its edge.
  function automatic vec_t bt(input logic sop, input logic eop, input logic err,
                              input logic [63:0] d, input logic [2:0] e);
    return mk(1'b1, sop, eop, err, d, e, 1'b0, '0, '0);
  endfunction

  function automatic vec_t bub();
    return mk(1'b0, 1'b1, 1'b1, 1'b0, 64'h0001_0008_5555_5555, 3'd0, 1'b0, '0, '0);
  endfunction

  task automatic check_out(input string nm, input int idx, input logic ev,
                           input logic [255:0] ed, input logic [31:0] em);
    n_chk++;
    if (out_valid !== ev || out_data !== ed || out_bytemask !== em) begin
      n_err++;
      $display("FAIL %s[%0d]: got v=%0b d=%h m=%h, want v=%0b d=%h m=%h",
               nm, idx, out_valid, out_data, out_bytemask, ev, ed, em);
    end
  endtask

  task automatic run_row(input vec_t r, input string nm, input int idx);
    @(negedge clk);
    in_valid          = r.v;
    in_startofpayload = r.sop;
    in_endofpayload   = r.eop;
    in_error          = r.err;
    in_data           = r.d;
    in_empty          = r.e;
    @(posedge clk);
    #1;
    check_out(nm, idx, r.ev, r.ed, r.em);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_startofpayload = 1'b0; in_endofpayload = 1'b0;
    in_error = 1'b0; in_data = '0; in_empty = '0;
  endtask

  task automatic wait_ready(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = (in_ready === 1'b1);
    end
    n_chk++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: in_ready=%0b, want 1 within 4 cycles", nm, in_ready);
    end
  endtask

  task automatic do_reset_checks(input string nm);
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_bytemask !== '0) begin
      n_err++;
      $display("FAIL %s: got rdy=%0b v=%0b d=%h m=%h, want all 0",
               nm, in_ready, out_valid, out_data, out_bytemask);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset_checks("reset_state");
    @(negedge clk);
    reset = 1'b0;
    wait_ready("ready_after_reset");

    // Single message
    tbl.push_back(bt(1, 0, 0, 64'h0001_0008_AABB_CCDD, 3'd0));
    tbl.push_back(mk(1, 0, 1, 0, 64'hEEFF_0011_0000_0000, 3'd4, 1, 256'hAABBCCDDEEFF0011, 32'hFF));
    // Two messages, LEN 8 and 12
    tbl.push_back(bt(1, 0, 0, 64'h0002_0008_0102_0304, 3'd0));
    tbl.push_back(mk(1, 0, 0, 0, 64'h0506_0708_000C_1112, 3'd0, 1, 256'h0102030405060708, 32'hFF));
    tbl.push_back(bt(0, 0, 0, 64'h1314_1516_1718_191A, 3'd0));
    tbl.push_back(mk(1, 0, 1, 0, 64'h1B1C_0000_0000_0000, 3'd6, 1, 256'h1112131415161718191A1B1C, 32'h0FFF));
    // LEN field straddling beats (byte 7 / byte 0)
    tbl.push_back(bt(1, 0, 0, 64'h0002_000B_2122_2324, 3'd0));
    tbl.push_back(mk(1, 0, 0, 0, 64'h2526_2728_292A_2B00, 3'd0, 1, 256'h2122232425262728292A2B, 32'h7FF));
    tbl.push_back(bt(0, 0, 0, 64'h0831_3233_3435_3637, 3'd0));
    tbl.push_back(mk(1, 0, 1, 0, 64'h3800_0000_0000_0000, 3'd7, 1, 256'h3132333435363738, 32'hFF));
    // Maximum length 32
    tbl.push_back(bt(1, 0, 0, 64'h0001_0020_0001_0203, 3'd0));
    tbl.push_back(bt(0, 0, 0, 64'h0405_0607_0809_0A0B, 3'd0));
    tbl.push_back(bt(0, 0, 0, 64'h0C0D_0E0F_1011_1213, 3'd0));
    tbl.push_back(bt(0, 0, 0, 64'h1415_1617_1819_1A1B, 3'd0));
    tbl.push_back(mk(1, 0, 1, 0, 64'h1C1D_1E1F_0000_0000, 3'd4, 1,
      256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F, 32'hFFFF_FFFF));
    // Error in the body of message 2 of 3 (it would complete in the errored beat)
    tbl.push_back(bt(1, 0, 0, 64'h0003_0008_A0A1_A2A3, 3'd0));
    tbl.push_back(mk(1, 0, 0, 0, 64'hA4A5_A6A7_0008_B0B1, 3'd0, 1, 256'hA0A1A2A3A4A5A6A7, 32'hFF));
    tbl.push_back(bt(0, 0, 1, 64'hB2B3_B4B5_B6B7_0008, 3'd0));
    tbl.push_back(bt(0, 1, 0, 64'hC0C1_C2C3_C4C5_C6C7, 3'd0));
    // Next payload decodes normally
    tbl.push_back(bt(1, 0, 0, 64'h0001_0008_AABB_CCDD, 3'd0));
    tbl.push_back(mk(1, 0, 1, 0, 64'hEEFF_0011_0000_0000, 3'd4, 1, 256'hAABBCCDDEEFF0011, 32'hFF));
    // Truncation: eop 3 bytes short; padding bytes must not count
    tbl.push_back(bt(1, 0, 0, 64'h0001_0008_D0D1_D2D3, 3'd0));
    tbl.push_back(bt(0, 1, 0, 64'hD400_0000_0000_0000, 3'd7));
    // Illegal LEN=5, followed by bytes that look like a legal record
    tbl.push_back(bt(1, 0, 0, 64'h0001_0005_1122_3344, 3'd0));
    tbl.push_back(bt(0, 0, 0, 64'h5500_0861_6263_6465, 3'd0));
    tbl.push_back(bt(0, 1, 0, 64'h6667_6800_0000_0000, 3'd5));
    // MSG_COUNT = 0
    tbl.push_back(bt(1, 0, 0, 64'h0000_0008_0102_0304, 3'd0));
    tbl.push_back(bt(0, 1, 0, 64'h0506_0708_0000_0000, 3'd4));
    // Trailing bytes after the last counted message are ignored
    tbl.push_back(bt(1, 0, 0, 64'h0001_0008_E0E1_E2E3, 3'd0));
    tbl.push_back(mk(1, 0, 0, 0, 64'hE4E5_E6E7_0008_F0F1, 3'd0, 1, 256'hE0E1E2E3E4E5E6E7, 32'hFF));
    tbl.push_back(bt(0, 1, 0, 64'hF2F3_F4F5_F6F7_0000, 3'd2));
    // Beats outside a payload are ignored
    tbl.push_back(bt(0, 0, 0, 64'h0001_0008_1122_3344, 3'd0));
    tbl.push_back(bt(0, 1, 0, 64'h5566_7788_0000_0000, 3'd4));
    // New sop abandons an unfinished payload
    tbl.push_back(bt(1, 0, 0, 64'h0002_0008_0102_0304, 3'd0));
    tbl.push_back(bt(1, 0, 0, 64'h0001_0008_AABB_CCDD, 3'd0));
    tbl.push_back(mk(1, 0, 1, 0, 64'hEEFF_0011_0000_0000, 3'd4, 1, 256'hAABBCCDDEEFF0011, 32'hFF));
    // Bubbles between beats of a legal payload
    tbl.push_back(bt(1, 0, 0, 64'h0002_0008_0102_0304, 3'd0));
    tbl.push_back(bub());
    tbl.push_back(bub());
    tbl.push_back(mk(1, 0, 0, 0, 64'h0506_0708_000C_1112, 3'd0, 1, 256'h0102030405060708, 32'hFF));
    tbl.push_back(bub());
    tbl.push_back(bt(0, 0, 0, 64'h1314_1516_1718_191A, 3'd0));
    tbl.push_back(bub());
    tbl.push_back(mk(1, 0, 1, 0, 64'h1B1C_0000_0000_0000, 3'd6, 1, 256'h1112131415161718191A1B1C, 32'h0FFF));
    tbl.push_back(bub());

    foreach (tbl[i]) run_row(tbl[i], "vec", i);

    // Reset asserted mid-message, right after a pulse
    run_row(bt(1, 0, 0, 64'h0002_0008_0102_0304, 3'd0), "rst_seq", 0);
    run_row(mk(1, 0, 0, 0, 64'h0506_0708_000C_1112, 3'd0, 1, 256'h0102030405060708, 32'hFF), "rst_seq", 1);
    #2;
    reset = 1'b1;
    idle_inputs();
    #1;
    do_reset_checks("reset_mid_msg");
    @(negedge clk);
    reset = 1'b0;
    wait_ready("ready_after_mid_reset");
    // Continuation of the discarded payload must produce nothing
    run_row(bt(0, 0, 0, 64'h1314_1516_1718_191A, 3'd0), "rst_seq", 2);
    run_row(bt(0, 1, 0, 64'h1B1C_0000_0000_0000, 3'd6), "rst_seq", 3);
    run_row(bt(1, 0, 0, 64'h0001_0008_AABB_CCDD, 3'd0), "rst_seq", 4);
    run_row(mk(1, 0, 1, 0, 64'hEEFF_0011_0000_0000, 3'd4, 1, 256'hAABBCCDDEEFF0011, 32'hFF), "rst_seq", 5);
    run_row(bub(), "rst_seq", 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
